// File: rtl/pipe_skid_reg.sv
// Two-entry registered pipeline slice: forward data/valid and backward ready are
// all flops, so a long path can be cut in both directions without losing beats.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             i_vld,
  output logic             i_rdy,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_vld,
  input  logic             o_rdy,
  output logic [WIDTH-1:0] o_dat,
  output logic [1:0]       o_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_vld;
  logic             r_rdy;
  logic             w_acc;
  logic             w_take;

  // Handshake: a beat moves on any edge where valid and ready are both high.
  assign w_acc  = i_vld & r_rdy;
  assign w_take = r_vld & o_rdy;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= ST_EMPTY;
      r_vld   <= 1'b0;
      r_rdy   <= 1'b1;
      r_main  <= RESET_VALUE;
      r_skid  <= RESET_VALUE;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_main  <= i_dat;
            r_vld   <= 1'b1;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_acc && w_take) begin
            r_main <= i_dat;
          end else if (w_acc) begin
            r_skid  <= i_dat;
            r_rdy   <= 1'b0;
            r_state <= ST_FULL;
          end else if (w_take) begin
            r_vld   <= 1'b0;
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Skid word moves up; ready returns one cycle after the take.
          if (w_take) begin
            r_main  <= r_skid;
            r_rdy   <= 1'b1;
            r_state <= ST_ONE;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_vld   <= 1'b0;
          r_rdy   <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    o_cnt = 2'd0;
    case (r_state)
      ST_EMPTY: o_cnt = 2'd0;
      ST_ONE:   o_cnt = 2'd1;
      ST_FULL:  o_cnt = 2'd2;
      default:  o_cnt = 2'd0;
    endcase
  end

  assign i_rdy = r_rdy;
  assign o_vld = r_vld;
  assign o_dat = r_main;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: a depth-2 FIFO reference model with an expected-data
// queue predicts every output each cycle.
module tb_pipe_skid_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         i_vld;
  logic         i_rdy;
  logic [W-1:0] i_dat;
  logic         o_vld;
  logic         o_rdy;
  logic [W-1:0] o_dat;
  logic [1:0]   o_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_last;

  pipe_skid_reg #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .i_dat (i_dat),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_dat (o_dat),
    .o_cnt (o_cnt)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model (called mid-cycle, away from the edge).
  task automatic check_outputs(input string tag);
    logic [W-1:0] exp_dat;
    logic [1:0]   exp_cnt;
    exp_dat = (exp_q.size() > 0) ? exp_q[0] : m_last;
    exp_cnt = 2'(exp_q.size());
    check_bit({tag, ".o_vld"}, o_vld, exp_q.size() > 0);
    check_bit({tag, ".i_rdy"}, i_rdy, exp_q.size() < 2);
    check_vec({tag, ".o_cnt"}, {6'd0, o_cnt}, {6'd0, exp_cnt});
    check_vec({tag, ".o_dat"}, o_dat, exp_dat);
  endtask

  // Driver: check current outputs, drive one cycle of inputs, then update the model.
  task automatic step(input string tag, input logic v, input logic [W-1:0] d,
                      input logic r, input logic fl, input logic rs,
                      output logic accepted);
    logic acc;
    logic take;
    @(negedge clk);
    check_outputs(tag);
    i_vld = v;
    i_dat = d;
    o_rdy = r;
    flush = fl;
    rst   = rs;
    take = (exp_q.size() > 0) && r;
    acc  = v && (exp_q.size() < 2);
    @(posedge clk);
    accepted = acc && !rs && !fl;
    if (rs || fl) begin
      exp_q.delete();
      m_last = 8'h00;
    end else begin
      if (take) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(d);
      if (exp_q.size() > 0) m_last = exp_q[0];
    end
  endtask

  initial begin
    logic acc;
    int   n_acc;
    int   cycles;

    rst = 1'b1; flush = 1'b0; i_vld = 1'b1; i_dat = 8'hAA; o_rdy = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    m_last = 8'h00;

    // Reset held with a valid beat offered: nothing captured
    step("reset_hold", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, acc);
    step("reset_rel",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
    step("reset_idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

    // Streaming at full throughput
    for (int k = 1; k <= 16; k++)
      step("stream", 1'b1, W'(k), 1'b1, 1'b0, 1'b0, acc);
    step("stream_tail", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
    step("stream_done", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

    // Backpressure fills the skid, then drains in order
    step("bp_a11",   1'b1, 8'h11, 1'b0, 1'b0, 1'b0, acc);
    step("bp_a22",   1'b1, 8'h22, 1'b0, 1'b0, 1'b0, acc);
    step("bp_full",  1'b1, 8'h99, 1'b0, 1'b0, 1'b0, acc);
    step("bp_take1", 1'b1, 8'h98, 1'b1, 1'b0, 1'b0, acc);
    step("bp_take2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
    step("bp_empty", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
    step("bp_idle",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);

    // Random valid/ready stalls, bounded cycle budget
    n_acc = 0;
    cycles = 0;
    while (n_acc < 1000 && cycles < 8000) begin
      step("rand", 1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'b0, 1'b0, acc);
      if (acc) n_acc++;
      cycles++;
    end
    tests_run++;
    assert (n_acc == 1000) else begin
      tests_failed++;
      $error("FAIL rand_budget observed=%0d expected=1000", n_acc);
    end
    for (int k = 0; k < 4; k++)
      step("rand_drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

    // Flush from FULL drops everything, including the beat offered that cycle
    step("fl_a33",   1'b1, 8'h33, 1'b0, 1'b0, 1'b0, acc);
    step("fl_a44",   1'b1, 8'h44, 1'b0, 1'b0, 1'b0, acc);
    step("fl_pulse", 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, acc);
    step("fl_after", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
    step("fl_quiet", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

    // Mid-operation reset while FULL with the consumer ready
    step("mr_a66",   1'b1, 8'h66, 1'b0, 1'b0, 1'b0, acc);
    step("mr_a77",   1'b1, 8'h77, 1'b0, 1'b0, 1'b0, acc);
    step("mr_rst",   1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);
    step("mr_after", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
    step("mr_quiet", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

    @(negedge clk);
    check_outputs("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
